// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared CPU definitions: datapath defaults and load funct3 codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_type_e;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Extracts and extends the addressed byte/halfword of a loaded word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] dm_out_i,
    input  logic [2:0]        ld_type_i,
    input  logic [1:0]        byte_off_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = dm_out_i[{byte_off_i, 3'b000} +: 8];
    assign w_half = dm_out_i[{byte_off_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = dm_out_i;
        case (ld_type_i)
            LD_LB:   ld_data_o = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_LH:   ld_data_o = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_LBU:  ld_data_o = {{(DATA_W-8){1'b0}}, w_byte};
            LD_LHU:  ld_data_o = {{(DATA_W-16){1'b0}}, w_half};
            default: ld_data_o = dm_out_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline buffer: small FIFO holding final writeback values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_rd_data,
    input  logic [DATA_W-1:0]          in_dm_out,
    input  logic [REG_W-1:0]           in_rd_addr,
    input  logic                       in_reg_wr,
    input  logic                       in_dm2reg,
    input  logic [2:0]                 in_ld_type,
    input  logic [1:0]                 in_byte_off,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [REG_W-1:0]           wb_rd_addr,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       wb_reg_wr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [REG_W-1:0]  addr_q [DEPTH];
    logic              we_q   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_wb_data;

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .dm_out_i   (in_dm_out),
        .ld_type_i  (in_ld_type),
        .byte_off_i (in_byte_off),
        .ld_data_o  (w_ld_data)
    );

    // Writeback value is resolved at push so the read side is a plain mux.
    assign w_wb_data = in_dm2reg ? w_ld_data : in_rd_data;

    assign in_ready = (count_q < C_DEPTH);
    assign wb_valid = (count_q != '0);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = wb_valid && wb_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (w_pop && !w_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push) begin
            data_q[wr_ptr_q] <= w_wb_data;
            addr_q[wr_ptr_q] <= in_rd_addr;
            we_q[wr_ptr_q]   <= in_reg_wr && (in_rd_addr != '0);
        end
    end

    assign wb_data    = wb_valid ? data_q[rd_ptr_q] : '0;
    assign wb_rd_addr = wb_valid ? addr_q[rd_ptr_q] : '0;
    assign wb_reg_wr  = wb_valid ? we_q[rd_ptr_q]   : 1'b0;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

    logic        ACLK;
    logic        ARESETn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rd_data;
    logic [31:0] in_dm_out;
    logic [4:0]  in_rd_addr;
    logic        in_reg_wr;
    logic        in_dm2reg;
    logic [2:0]  in_ld_type;
    logic [1:0]  in_byte_off;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        wb_reg_wr;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    mem_wb_stage u_dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd_data  (in_rd_data),
        .in_dm_out   (in_dm_out),
        .in_rd_addr  (in_rd_addr),
        .in_reg_wr   (in_reg_wr),
        .in_dm2reg   (in_dm2reg),
        .in_ld_type  (in_ld_type),
        .in_byte_off (in_byte_off),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd_addr  (wb_rd_addr),
        .wb_data     (wb_data),
        .wb_reg_wr   (wb_reg_wr),
        .count       (count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample away from it.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] dm,
                         input logic [4:0] a, input logic we, input logic d2r,
                         input logic [2:0] lt, input logic [1:0] off);
        in_valid    = v;
        in_rd_data  = rd;
        in_dm_out   = dm;
        in_rd_addr  = a;
        in_reg_wr   = we;
        in_dm2reg   = d2r;
        in_ld_type  = lt;
        in_byte_off = off;
    endtask

    initial begin
        ARESETn  = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'd0);
        step();
        step();
        chk("rst_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_count", {30'b0, count}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_addr", {27'b0, wb_rd_addr}, 32'd0);
        chk("rst_we", {31'b0, wb_reg_wr}, 32'd0);
        ARESETn = 1'b1;

        // LB byte 1 of 0x00008000 -> 0x80 sign-extended
        drive(1'b1, 32'h0, 32'h0000_8000, 5'd1, 1'b1, 1'b1, 3'b000, 2'd1);
        step();
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_valid", {31'b0, wb_valid}, 32'd1);
        chk("lb_count", {30'b0, count}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'd0);
        wb_ready = 1'b1;
        step();
        chk("pop_count", {30'b0, count}, 32'd0);
        chk("empty_data", wb_data, 32'd0);
        wb_ready = 1'b0;

        // LHU upper half, then LH pushed while popping at count=1
        drive(1'b1, 32'h0, 32'hBEEF_1234, 5'd2, 1'b1, 1'b1, 3'b101, 2'd2);
        step();
        chk("lhu_data", wb_data, 32'h0000_BEEF);
        drive(1'b1, 32'h0, 32'hBEEF_1234, 5'd4, 1'b1, 1'b1, 3'b001, 2'd3);
        wb_ready = 1'b1;
        step();
        chk("pp_count", {30'b0, count}, 32'd1);
        chk("lh_data", wb_data, 32'hFFFF_BEEF);
        chk("lh_addr", {27'b0, wb_rd_addr}, 32'd4);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'd0);
        step();
        chk("pp_drain", {30'b0, count}, 32'd0);
        wb_ready = 1'b0;

        // Backpressure: three offers, only two accepted, drain in order
        drive(1'b1, 32'h1234_5678, 32'h0, 5'd7, 1'b1, 1'b0, 3'b010, 2'd0);
        step();
        chk("bp1_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b1, 32'h0, 32'hA500_1122, 5'd9, 1'b1, 1'b1, 3'b100, 2'd3);
        step();
        chk("bp2_ready", {31'b0, in_ready}, 32'd0);
        chk("bp2_count", {30'b0, count}, 32'd2);
        drive(1'b1, 32'h0, 32'hCAFE_F00D, 5'd3, 1'b1, 1'b1, 3'b010, 2'd0);
        step();
        chk("bp3_count", {30'b0, count}, 32'd2);
        chk("bp3_head", wb_data, 32'h1234_5678);
        chk("bp3_addr", {27'b0, wb_rd_addr}, 32'd7);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'd0);
        wb_ready = 1'b1;
        step();
        chk("drain1_data", wb_data, 32'h0000_00A5);
        chk("drain1_addr", {27'b0, wb_rd_addr}, 32'd9);
        step();
        chk("drain2_valid", {31'b0, wb_valid}, 32'd0);
        wb_ready = 1'b0;

        // Undefined funct3 behaves as LW; then flush with a concurrent push
        drive(1'b1, 32'h0, 32'h8000_0001, 5'd6, 1'b1, 1'b1, 3'b111, 2'd2);
        step();
        chk("ldx_data", wb_data, 32'h8000_0001);
        drive(1'b1, 32'h5555_AAAA, 32'h0, 5'd8, 1'b1, 1'b0, 3'b010, 2'd0);
        step();
        chk("fl_pre", {30'b0, count}, 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'h7777_7777, 32'h0, 5'd10, 1'b1, 1'b0, 3'b010, 2'd0);
        step();
        chk("fl_count", {30'b0, count}, 32'd0);
        chk("fl_valid", {31'b0, wb_valid}, 32'd0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'd0);
        step();
        chk("fl_lost", {30'b0, count}, 32'd0);

        // x0 destination never writes; then reset mid-stream
        drive(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 1'b0, 3'b010, 2'd0);
        step();
        chk("x0_we", {31'b0, wb_reg_wr}, 32'd0);
        chk("x0_valid", {31'b0, wb_valid}, 32'd1);
        drive(1'b1, 32'h0000_0011, 32'h0, 5'd5, 1'b1, 1'b0, 3'b010, 2'd0);
        step();
        chk("x0_count", {30'b0, count}, 32'd2);
        chk("x0_head_data", wb_data, 32'hDEAD_BEEF);
        ARESETn  = 1'b0;
        wb_ready = 1'b1;
        step();
        chk("mrst_count", {30'b0, count}, 32'd0);
        chk("mrst_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_data", wb_data, 32'd0);
        ARESETn = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b010, 2'd0);
        step();
        chk("post_rst", {30'b0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
